// File: rtl/out_buf_write_arbiter.sv
// Arbitrates PE write requests onto the single output-buffer write port.
// Round-robin by default; define WB_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module out_buf_write_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DEPTH   = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      buf_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        stall,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      buf_full,
  output logic                      pass_done
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic               win_vld;
  logic [PTR_W-1:0]   win_idx;
  logic               fire;
  logic               last;

`ifdef WB_ARB_FIXED_PRIO_EN
  // Lowest requesting index wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(i);
      end
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr;

  // First requester at or after rr_ptr; scanned downward so the nearest one is kept.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = 32'(rr_ptr) + 32'(k);
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx[PTR_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = idx[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (start) begin
      rr_ptr <= '0;
    end else if (fire) begin
      rr_ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : PTR_W'(win_idx + PTR_W'(1));
    end
  end
`endif

  assign fire = (state == RUN) && buf_ready && win_vld;
  assign last = (count == CNT_W'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = '0;
    stall     = '0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (fire) grant = NUM_REQ'(1) << win_idx;
        stall = req & ~grant;
        // A restart outranks completing the pass.
        if (start)             state_nxt = RUN;
        else if (fire && last) state_nxt = FULL;
      end
      FULL: begin
        stall = req;
        if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write port, word count and pass status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      count     <= '0;
      buf_full  <= 1'b0;
      pass_done <= 1'b0;
    end else begin
      wr_en     <= fire;
      pass_done <= fire && (state_nxt == FULL);
      buf_full  <= (state_nxt == FULL);
      if (fire) begin
        wr_addr <= count[ADDR_W-1:0];
        wr_data <= req_data[int'(win_idx)*DATA_W +: DATA_W];
      end
      if (start)     count <= '0;
      else if (fire) count <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_out_buf_write_arbiter.sv
// Self-checking bench for out_buf_write_arbiter: directed table, reset cases, random vs model.
module tb_out_buf_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DP = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            buf_ready = 1'b0;
  logic [N-1:0]    grant, stall;
  logic            wr_en, buf_full, pass_done;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;

  out_buf_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .start(start), .req(req), .req_data(req_data),
    .buf_ready(buf_ready), .grant(grant), .stall(stall), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .buf_full(buf_full), .pass_done(pass_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: mode 0 idle, 1 running, 2 full.
  int        m_mode = 0, m_count = 0, m_ptr = 0;
  logic      m_wr = 0, m_full = 0, m_done = 0;
  int        m_addr = 0;
  logic [DW-1:0] m_data = '0;

  typedef struct {
    logic         s;
    logic [N-1:0] r;
    logic         rdy;
    int           eg;
    int           es;
    int           ea;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic [N-1:0] r, logic rdy, int eg, int es, int ea);
    vec_t v;
    v.s = s; v.r = r; v.rdy = rdy; v.eg = eg; v.es = es; v.ea = ea;
    return v;
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int model_winner(logic [N-1:0] r, logic rdy);
    if (m_mode != 1 || !rdy || r == 0) return -1;
`ifdef WB_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 0; k < N; k++) if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
    return -1;
  endfunction

  task automatic step(input logic s, input logic [N-1:0] r, input logic [N*DW-1:0] d,
                      input logic rdy, input int eg, input int es, input int ea);
    int w;
    logic [N-1:0] xg, xs;
    @(negedge clk);
    start = s; req = r; req_data = d; buf_ready = rdy;
    #1;
    w  = model_winner(r, rdy);
    xg = (w >= 0) ? N'(1) << w : '0;
    xs = (m_mode == 0) ? '0 : (r & ~xg);
    chk("grant", 64'(grant), 64'(xg));
    chk("stall", 64'(stall), 64'(xs));
    if (eg >= 0) begin
      chk("tbl_grant", 64'(grant), 64'(eg));
      chk("tbl_stall", 64'(stall), 64'(es));
    end
    @(posedge clk);
    m_wr = (w >= 0);
    if (w >= 0) begin
      m_addr = m_count;
      m_data = d[w*DW +: DW];
    end
    m_done = 0;
    if (s) begin
      m_mode = 1; m_count = 0; m_ptr = 0;
    end else if (w >= 0) begin
      m_count++;
      m_ptr = (w + 1) % N;
      if (m_count == DP) begin
        m_mode = 2; m_done = 1;
      end
    end
    m_full = (m_mode == 2);
    #1;
    chk("wr_en", 64'(wr_en), 64'(m_wr));
    if (m_wr) begin
      chk("wr_addr", 64'(wr_addr), 64'(m_addr));
      chk("wr_data", 64'(wr_data), 64'(m_data));
    end
    chk("buf_full", 64'(buf_full), 64'(m_full));
    chk("pass_done", 64'(pass_done), 64'(m_done));
    if (ea != -2) begin
      chk("tbl_wr_en", 64'(wr_en), 64'(ea >= 0));
      if (ea >= 0) chk("tbl_wr_addr", 64'(wr_addr), 64'(ea));
    end
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic rst_check();
    req = '1; buf_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_buf_full", 64'(buf_full), 64'(0));
    chk("rst_pass_done", 64'(pass_done), 64'(0));
    m_mode = 0; m_count = 0; m_ptr = 0; m_wr = 0; m_full = 0; m_done = 0;
    @(negedge clk);
    rst = 1'b0; req = '0; buf_ready = 1'b0;
  endtask

  initial begin
    logic [N*DW-1:0] d;
`ifdef WB_ARB_FIXED_PRIO_EN
    tbl.push_back(mk(1, 4'b1010, 1, 0, 0, -1));
    for (int a = 0; a < DP; a++) tbl.push_back(mk(0, 4'b1010, 1, 2, 8, a));
    tbl.push_back(mk(0, 4'b1010, 1, 0, 10, -1));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 0, -1));
    tbl.push_back(mk(0, 4'b1010, 0, 0, 10, -1));
    tbl.push_back(mk(0, 4'b1010, 1, 2, 8, 0));
`else
    tbl.push_back(mk(1, 4'b0001, 1, 0, 0, -1));
    tbl.push_back(mk(0, 4'b0001, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 0, -1));
    tbl.push_back(mk(0, 4'b1111, 1, 1, 14, 0));
    tbl.push_back(mk(0, 4'b1110, 1, 2, 12, 1));
    tbl.push_back(mk(0, 4'b1100, 1, 4, 8, 2));
    tbl.push_back(mk(0, 4'b1000, 1, 8, 0, 3));
    for (int c = 0; c < 3; c++) tbl.push_back(mk(0, 4'b0110, 0, 0, 6, -1));
    tbl.push_back(mk(0, 4'b0110, 1, 2, 4, 4));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 0, -1));
    tbl.push_back(mk(0, 4'b1111, 1, 4, 11, 5));
    tbl.push_back(mk(0, 4'b1011, 1, 8, 3, 6));
    tbl.push_back(mk(0, 4'b0011, 1, 1, 2, 7));
    tbl.push_back(mk(0, 4'b0010, 1, 0, 2, -1));
    tbl.push_back(mk(1, 4'b0010, 1, 0, 2, -1));
    tbl.push_back(mk(0, 4'b0010, 1, 2, 0, 0));
    tbl.push_back(mk(1, 4'b0100, 1, 4, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 1, 4, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 0, -1));
`endif

    #2;
    rst_check();

    foreach (tbl[k]) begin
      d = {16'(32'h0300 + k), 16'(32'h0200 + k), 16'(32'h0100 + k), 16'(32'h00A0 + k)};
      step(tbl[k].s, tbl[k].r, d, tbl[k].rdy, tbl[k].eg, tbl[k].es, tbl[k].ea);
    end

    // Reset while a write strobe is on the port.
    rst_check();
    step(1, 4'b0000, '0, 1, -1, -1, -2);
    step(0, 4'b0001, {4{16'h5A5A}}, 1, -1, -1, 0);
    #1;
    rst_check();
    step(0, 4'b1111, {4{16'h1234}}, 1, 0, 0, -1);

    for (int c = 0; c < 800; c++) begin
      d = {$urandom, $urandom};
      step(($urandom % 20) == 0, N'($urandom), d, ($urandom % 4) != 0, -1, -1, -2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
